stopwatch_ctrl: RTL

//   Front-end control stage for the two-digit seven-segment stopwatch counter.

---
 rtl/stopwatch_pkg.sv | 16 +
 rtl/btn_debounce.sv | 63 ++++++
 rtl/stopwatch_ctrl.sv | 122 ++++++++++++
 3 files changed

// File: rtl/stopwatch_pkg.sv
// Shared definitions for the stopwatch control front-end: FSM state
// encoding and the bit positions of the three buttons in the press vector.
package stopwatch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_RUN   = 2'b01,
        ST_PAUSE = 2'b10
    } state_t;

    localparam int BTN_START = 0;
    localparam int BTN_STOP  = 1;
    localparam int BTN_CLEAR = 2;
    localparam int NUM_BTNS  = 3;

endpackage

// File: rtl/btn_debounce.sv
// One push-button path: two-flop synchroniser, stability-counting debounce
// and a single-cycle pulse on each accepted press (rising debounced edge).
module btn_debounce #(
    parameter int DB_CYCLES = 1000000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic raw,
    output logic level,
    output logic press
);

    localparam int CW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DB_CYCLES - 1);

    logic          r_sync1;
    logic          r_sync2;
    logic          r_level;
    logic          r_levelDly;
    logic          r_press;
    logic [CW-1:0] r_cnt;

    // Bring the asynchronous button into the clk domain through two flops.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= raw;
            r_sync2 <= r_sync1;
        end
    end

    // Accept a new level only after it has differed for DB_CYCLES edges in a row.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt   <= '0;
            r_level <= 1'b0;
        end else if (r_sync2 == r_level) begin
            r_cnt <= '0;
        end else if (r_cnt == CNT_MAX) begin
            r_level <= r_sync2;
            r_cnt   <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // Registered rising-edge detect so press is a clean one-cycle pulse.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_levelDly <= 1'b0;
            r_press    <= 1'b0;
        end else begin
            r_levelDly <= r_level;
            r_press    <= r_level & ~r_levelDly;
        end
    end

    assign level = r_level;
    assign press = r_press;

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch control stage: debounces start/stop/clear, runs the
// IDLE/RUN/PAUSE machine and produces the counter's tick enable.
module stopwatch_ctrl
    import stopwatch_pkg::*;
#(
    parameter int DB_CYCLES = 1000000,
    parameter int TICK_DIV  = 25000000
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       btn_start,
    input  logic       btn_stop,
    input  logic       btn_clear,
    output logic       en,
    output logic       stop,
    output logic       clear,
    output logic       tick,
    output logic [1:0] state
);

    localparam int TW = $clog2(TICK_DIV);
    localparam logic [TW-1:0] TICK_MAX = TW'(TICK_DIV - 1);

    logic [NUM_BTNS-1:0] w_raw;
    logic [NUM_BTNS-1:0] w_level;
    logic [NUM_BTNS-1:0] w_press;

    state_t        r_state;
    state_t        w_nextState;
    logic          w_clearReq;
    logic          r_clear;
    logic          r_tick;
    logic [TW-1:0] r_prescale;

    assign w_raw[BTN_START] = btn_start;
    assign w_raw[BTN_STOP]  = btn_stop;
    assign w_raw[BTN_CLEAR] = btn_clear;

    for (genvar g = 0; g < NUM_BTNS; g++) begin : gBtn
        btn_debounce #(
            .DB_CYCLES(DB_CYCLES)
        ) uDebounce (
            .clk    (clk),
            .reset_n(reset_n),
            .raw    (w_raw[g]),
            .level  (w_level[g]),
            .press  (w_press[g])
        );
    end

    // Next-state logic; clear beats stop beats start, and a stop press
    // swallows a coincident start even where stop itself has no effect.
    always_comb begin
        w_nextState = r_state;
        w_clearReq  = 1'b0;
        if (w_press[BTN_CLEAR]) begin
            w_nextState = ST_IDLE;
            w_clearReq  = 1'b1;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (!w_press[BTN_STOP] && w_press[BTN_START]) begin
                        w_nextState = ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (w_press[BTN_STOP]) begin
                        w_nextState = ST_PAUSE;
                    end
                end
                ST_PAUSE: begin
                    if (!w_press[BTN_STOP] && w_press[BTN_START]) begin
                        w_nextState = ST_RUN;
                    end
                end
                default: begin
                    w_nextState = ST_IDLE;
                end
            endcase
        end
    end

    // State register, with the clear pulse registered alongside so it
    // lines up with the first cycle that reads IDLE.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
            r_clear <= 1'b0;
        end else begin
            r_state <= w_nextState;
            r_clear <= w_clearReq;
        end
    end

    // Tick prescaler: advances only while staying in RUN, keeps its partial
    // count across PAUSE, restarts from zero when leaving or entering IDLE.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_prescale <= '0;
            r_tick     <= 1'b0;
        end else begin
            r_tick <= 1'b0;
            if (r_state == ST_RUN && w_nextState == ST_RUN) begin
                if (r_prescale == TICK_MAX) begin
                    r_prescale <= '0;
                    r_tick     <= 1'b1;
                end else begin
                    r_prescale <= r_prescale + 1'b1;
                end
            end else if (w_nextState == ST_IDLE || r_state == ST_IDLE) begin
                r_prescale <= '0;
            end
        end
    end

    assign en    = (r_state == ST_RUN) || (r_state == ST_PAUSE);
    assign stop  = (r_state == ST_PAUSE);
    assign clear = r_clear;
    assign tick  = r_tick;
    assign state = r_state;

endmodule
